scie_dispatch: RTL and testbench
================================

Name: scie_dispatch

Overview:
- Decoupling front-end that sits directly upstream of the SCIE pipelined unit and also captures its results.
- Accepts custom-instruction commands (insn, rs1, rs2, destination tag) over a ready/valid interface and buffers them in a command FIFO.
- Issues at most one command per cycle to the SCIE unit's fixed-latency, non-stallable port, tracks in-flight operations, and collects scie_rd into a response FIFO drained via ready/valid.
- Issue credits guarantee the response FIFO never overflows.

Parameters:
- XLEN, 32, width of insn/rs1/rs2/rd.
- TAG_W, 5, width of destination tag carried alongside each op.
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- RSP_DEPTH, 4, response FIFO entries (power of 2, >=2).
- LATENCY, 2, clock edges from the edge sampling scie_valid=1 to the edge at which scie_rd is valid (>=1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO not full.
- cmd_insn  in  XLEN  instruction word.
- cmd_rs1  in  XLEN  source operand 1.
- cmd_rs2  in  XLEN  source operand 2.
- cmd_tag  in  TAG_W  destination tag.
- scie_valid  out  1  issue strobe to SCIE unit (registered).
- scie_insn  out  XLEN  registered instruction to SCIE.
- scie_rs1  out  XLEN  registered operand 1 to SCIE.
- scie_rs2  out  XLEN  registered operand 2 to SCIE.
- scie_rd  in  XLEN  SCIE result.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  consumer accepts response.
- rsp_rd  out  XLEN  result at response FIFO head.
- rsp_tag  out  TAG_W  tag at response FIFO head.
- busy  out  1  any command queued, in flight, or response pending.

Behaviour:
- Reset (reset=0, asynchronous): FIFOs empty, delay line cleared, credits=RSP_DEPTH. Outputs: cmd_ready=1, scie_valid=0, scie_insn/rs1/rs2=0, rsp_valid=0, rsp_rd=0, rsp_tag=0, busy=0. Reset mid-operation discards queued, in-flight and pending results with no late writes.
- Command accept: on cmd_valid&cmd_ready. cmd_ready is registered-full based: !full. A push into a full FIFO never occurs, even with a same-cycle pop; cmd_ready returns the cycle after a pop.
- Issue condition: cmd FIFO non-empty AND inflight_cnt + rsp_count < RSP_DEPTH.
  - On issue: pop the head, load scie_insn/rs1/rs2, set scie_valid=1 for exactly that cycle, and push the tag plus valid bit into a LATENCY-deep delay line.
  - Otherwise scie_valid=0 and scie_insn/rs1/rs2 hold their previous values.
- Capture: when the delay-line tail is valid, push {scie_rd, tag} into the response FIFO at that edge.
- Latency: command accepted at edge 0 on an idle block → scie_valid high after edge 1 → result captured at edge 1+LATENCY → rsp_valid high after edge 1+LATENCY. Minimum cmd-to-rsp latency is LATENCY+1 edges.
- Throughput: one issue per cycle sustained while the consumer drains one response per cycle.
- Ordering: strictly in-order; responses leave in command order.
- Credit accounting: a same-cycle issue and response pop both update the count (net 0). A same-cycle capture and pop keep rsp_count unchanged.
- Response FIFO: rsp_rd/rsp_tag show the head when rsp_valid=1 and hold the last value when empty. The head advances on rsp_valid&rsp_ready.
- Pointer wrap: modulo depth, with an extra pointer bit for full/empty.
- busy = cmd non-empty | any delay-line valid | rsp non-empty.

Optional Feature:
- SCIE_DISPATCH_FLUSH_EN
- Defined:
  - Adds input `flush` (1 bit, synchronous).
  - When flush=1: empty the command FIFO, clear the valid bits of all delay-line entries (those results are dropped at capture), force scie_valid=0 that cycle, and hold cmd_ready=0 that cycle.
  - The response FIFO is untouched; credits are recomputed accordingly.
- Undefined: no port and no flush logic.

Test Plan:
- Single op, LATENCY=2, stub SCIE returning rs1+rs2: cmd {insn=0x0B, rs1=79, rs2=0, tag=3} → scie_valid one cycle with rs1=79; rsp_valid after 3 edges; rsp_rd=79, rsp_tag=3; busy then 0.
- Back-to-back 4 cmds, rsp_ready=1: tags 1..4, rs1=17,18,19,20, rs2=1 → scie_valid 4 consecutive cycles; rsp_rd=18,19,20,21 in order with tags 1..4 on consecutive cycles.
- Backpressure, rsp_ready=0: push 10 cmds → exactly RSP_DEPTH=4 issues, cmd_ready=0 after 4 more queued. Raise rsp_ready → all 10 responses in order, no loss or duplication.
- Simultaneous issue+capture+pop in steady state with rsp_ready=1 → credit count constant; no issue stall once the pipeline is full.
- Reset asserted with 2 queued and 2 in flight → all outputs at reset values immediately. After release, no stale rsp_valid; a new cmd {rs1=99, rs2=1} → rsp_rd=100.
- (SCIE_DISPATCH_FLUSH_EN) flush with 2 in flight and 3 queued → none of those 5 responses appear; the previously buffered response is still delivered.

Source files
------------

// File: rtl/scie_dispatch.sv
// -----------------------------------------------------------------------------
// scie_dispatch
//
// Decoupling front-end for the SCIE pipelined unit. Commands arrive over a
// ready/valid port and wait in a command FIFO. At most one command per cycle
// is issued to the SCIE unit's fixed-latency, non-stallable port. A
// LATENCY-deep delay line carries each op's tag alongside it, and the result
// (scie_rd) is captured into a response FIFO that drains via ready/valid.
// An op is only issued if the response FIFO is guaranteed to have room for
// it, counting both the results still in flight and the entries already
// buffered. For that reason the response FIFO can never overflow.
//
// Optional build macro:
//   SCIE_DISPATCH_FLUSH_EN - adds a synchronous 'flush' input. Flush empties
//                            the command FIFO, drops every in-flight result
//                            and suppresses issue/accept for that cycle. The
//                            response FIFO is not affected.
//
// Ports:
//   clock                   sole clock, rising edge
//   reset                   asynchronous, active-low reset
//   flush                   (SCIE_DISPATCH_FLUSH_EN only) synchronous flush
//   cmd_valid/cmd_ready     command handshake
//   cmd_insn/rs1/rs2/tag    command payload
//   scie_valid              registered one-cycle issue strobe to SCIE
//   scie_insn/rs1/rs2       registered operands to SCIE
//   scie_rd                 SCIE result, valid LATENCY edges after issue
//   rsp_valid/rsp_ready     response handshake
//   rsp_rd/rsp_tag          response FIFO head (holds last value when empty)
//   busy                    anything queued, in flight or pending
// -----------------------------------------------------------------------------
module scie_dispatch #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int LATENCY   = 2
) (
  input  logic             clock,
  input  logic             reset,
`ifdef SCIE_DISPATCH_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [XLEN-1:0]  cmd_insn,
  input  logic [XLEN-1:0]  cmd_rs1,
  input  logic [XLEN-1:0]  cmd_rs2,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             scie_valid,
  output logic [XLEN-1:0]  scie_insn,
  output logic [XLEN-1:0]  scie_rs1,
  output logic [XLEN-1:0]  scie_rs2,
  input  logic [XLEN-1:0]  scie_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rd,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int CP    = $clog2(CMD_DEPTH);
  localparam int RP    = $clog2(RSP_DEPTH);
  // Wide enough for in-flight count plus buffered count.
  localparam int SUM_W = $clog2(LATENCY + RSP_DEPTH + 1) + 1;

  localparam logic [CP:0]      CPTR_ONE  = {{CP{1'b0}}, 1'b1};
  localparam logic [RP:0]      RPTR_ONE  = {{RP{1'b0}}, 1'b1};
  localparam logic [SUM_W-1:0] RSP_LIMIT = SUM_W'(RSP_DEPTH);

  // Flush request; constant low when the feature is not built in.
  logic flush_s;
`ifdef SCIE_DISPATCH_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  cmd_insn_mem [CMD_DEPTH];
  logic [XLEN-1:0]  cmd_rs1_mem  [CMD_DEPTH];
  logic [XLEN-1:0]  cmd_rs2_mem  [CMD_DEPTH];
  logic [TAG_W-1:0] cmd_tag_mem  [CMD_DEPTH];

  logic [CP:0] cmd_wptr_q, cmd_wptr_d;
  logic [CP:0] cmd_rptr_q, cmd_rptr_d;
  logic        cmd_empty_s, cmd_full_s, cmd_push_s;

  assign cmd_empty_s = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full_s  = (cmd_wptr_q[CP] != cmd_rptr_q[CP]) &&
                       (cmd_wptr_q[CP-1:0] == cmd_rptr_q[CP-1:0]);
  // Ready depends only on registered pointers, so a pop never frees a slot
  // for a push in the same cycle.
  assign cmd_ready   = !cmd_full_s && !flush_s;
  assign cmd_push_s  = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------------------
  // Delay line and response FIFO state
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [TAG_W-1:0]   dl_tag_q [LATENCY];

  logic [XLEN-1:0]  rsp_rd_mem  [RSP_DEPTH];
  logic [TAG_W-1:0] rsp_tag_mem [RSP_DEPTH];
  logic [RP:0]      rsp_wptr_q, rsp_wptr_d;
  logic [RP:0]      rsp_rptr_q, rsp_rptr_d;
  logic [RP:0]      rsp_cnt_s;
  logic             rsp_empty_s, rsp_pop_s, capture_s;
  logic [XLEN-1:0]  last_rd_q;
  logic [TAG_W-1:0] last_tag_q;

  assign rsp_empty_s = (rsp_wptr_q == rsp_rptr_q);
  assign rsp_cnt_s   = rsp_wptr_q - rsp_rptr_q;
  assign rsp_pop_s   = !rsp_empty_s && rsp_ready;
  // A result arriving during a flush belongs to a dropped op.
  assign capture_s   = dl_vld_q[LATENCY-1] && !flush_s;

  // ---------------------------------------------------------------------------
  // Issue credit check
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] inflight_s;
  logic [SUM_W-1:0] committed_s;
  logic             issue_s;

  // Count in-flight ops and add the buffered responses to get committed slots.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_s = inflight_s + {{(SUM_W-1){1'b0}}, dl_vld_q[i]};
    end
    committed_s = inflight_s + {{(SUM_W-RP-1){1'b0}}, rsp_cnt_s};
  end

  assign issue_s = !cmd_empty_s && (committed_s < RSP_LIMIT) && !flush_s;

  // Next-state for FIFO pointers and delay-line valid bits.
  always_comb begin
    cmd_wptr_d = cmd_wptr_q;
    cmd_rptr_d = cmd_rptr_q;
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    dl_vld_d   = {dl_vld_q[LATENCY-1:0], issue_s} >> 0;
    if (cmd_push_s) begin
      cmd_wptr_d = cmd_wptr_q + CPTR_ONE;
    end else begin
      cmd_wptr_d = cmd_wptr_q;
    end
    if (flush_s) begin
      cmd_rptr_d = cmd_wptr_q;
    end else if (issue_s) begin
      cmd_rptr_d = cmd_rptr_q + CPTR_ONE;
    end else begin
      cmd_rptr_d = cmd_rptr_q;
    end
    if (capture_s) begin
      rsp_wptr_d = rsp_wptr_q + RPTR_ONE;
    end else begin
      rsp_wptr_d = rsp_wptr_q;
    end
    if (rsp_pop_s) begin
      rsp_rptr_d = rsp_rptr_q + RPTR_ONE;
    end else begin
      rsp_rptr_d = rsp_rptr_q;
    end
    // Shift the valid bits toward the tail; flush kills every stage.
    if (flush_s) begin
      dl_vld_d = '0;
    end else begin
      dl_vld_d[0] = issue_s;
      for (int i = 1; i < LATENCY; i++) begin
        dl_vld_d[i] = dl_vld_q[i-1];
      end
    end
  end

  // Pointer, delay-line and issue-register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
      dl_vld_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_tag_q[i] <= '0;
      end
      scie_valid <= 1'b0;
      scie_insn  <= '0;
      scie_rs1   <= '0;
      scie_rs2   <= '0;
      last_rd_q  <= '0;
      last_tag_q <= '0;
    end else begin
      cmd_wptr_q <= cmd_wptr_d;
      cmd_rptr_q <= cmd_rptr_d;
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
      dl_vld_q   <= dl_vld_d;
      dl_tag_q[0] <= cmd_tag_mem[cmd_rptr_q[CP-1:0]];
      for (int i = 1; i < LATENCY; i++) begin
        dl_tag_q[i] <= dl_tag_q[i-1];
      end
      scie_valid <= issue_s;
      if (issue_s) begin
        scie_insn <= cmd_insn_mem[cmd_rptr_q[CP-1:0]];
        scie_rs1  <= cmd_rs1_mem[cmd_rptr_q[CP-1:0]];
        scie_rs2  <= cmd_rs2_mem[cmd_rptr_q[CP-1:0]];
      end
      // Remember the popped head so the outputs hold it once the FIFO drains.
      if (rsp_pop_s) begin
        last_rd_q  <= rsp_rd_mem[rsp_rptr_q[RP-1:0]];
        last_tag_q <= rsp_tag_mem[rsp_rptr_q[RP-1:0]];
      end
    end
  end

  // Command FIFO storage (data only; validity is tracked by the pointers).
  always_ff @(posedge clock) begin
    if (cmd_push_s) begin
      cmd_insn_mem[cmd_wptr_q[CP-1:0]] <= cmd_insn;
      cmd_rs1_mem[cmd_wptr_q[CP-1:0]]  <= cmd_rs1;
      cmd_rs2_mem[cmd_wptr_q[CP-1:0]]  <= cmd_rs2;
      cmd_tag_mem[cmd_wptr_q[CP-1:0]]  <= cmd_tag;
    end
  end

  // Response FIFO storage; room is guaranteed by the issue credit check.
  always_ff @(posedge clock) begin
    if (capture_s) begin
      rsp_rd_mem[rsp_wptr_q[RP-1:0]]  <= scie_rd;
      rsp_tag_mem[rsp_wptr_q[RP-1:0]] <= dl_tag_q[LATENCY-1];
    end
  end

  assign rsp_valid = !rsp_empty_s;
  assign rsp_rd    = rsp_empty_s ? last_rd_q  : rsp_rd_mem[rsp_rptr_q[RP-1:0]];
  assign rsp_tag   = rsp_empty_s ? last_tag_q : rsp_tag_mem[rsp_rptr_q[RP-1:0]];
  assign busy      = !cmd_empty_s || (|dl_vld_q) || !rsp_empty_s;

endmodule

// File: tb/tb_scie_dispatch.sv
// -----------------------------------------------------------------------------
// Testbench for scie_dispatch (default parameters, LATENCY=2).
// A stub SCIE unit returns rs1+rs2. Expected responses are queued when a
// command is accepted. A monitor branch pops them as the DUT hands out
// responses and compares.
// -----------------------------------------------------------------------------
module tb_scie_dispatch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_insn = '0;
  logic [31:0] cmd_rs1 = '0;
  logic [31:0] cmd_rs2 = '0;
  logic [4:0]  cmd_tag = '0;
  logic        scie_valid;
  logic [31:0] scie_insn, scie_rs1, scie_rs2;
  logic [31:0] stub_rd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rd;
  logic [4:0]  rsp_tag;
  logic        busy;
`ifdef SCIE_DISPATCH_FLUSH_EN
  logic        flush = 1'b0;
`endif

  scie_dispatch dut (
    .clock      (clock),
    .reset      (reset),
`ifdef SCIE_DISPATCH_FLUSH_EN
    .flush      (flush),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_insn   (cmd_insn),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_tag    (cmd_tag),
    .scie_valid (scie_valid),
    .scie_insn  (scie_insn),
    .scie_rs1   (scie_rs1),
    .scie_rs2   (scie_rs2),
    .scie_rd    (stub_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rd     (rsp_rd),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Stub SCIE unit: result valid LATENCY=2 edges after the issue edge.
  always @(posedge clock) stub_rd <= scie_rs1 + scie_rs2;

  typedef struct packed {
    logic [31:0] rd;
    logic [4:0]  tag;
  } rsp_t;

  rsp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int issue_cnt = 0, issue_run = 0, issue_max = 0;
  int pop_run = 0, pop_max = 0;
  int base;

  // Directed tables: backpressure run and steady-state run.
  logic [31:0] t3_rs1 [10] = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104,
                               32'd105, 32'd106, 32'd107, 32'd108, 32'd109};
  logic [31:0] t3_exp [10] = '{32'd105, 32'd106, 32'd107, 32'd108, 32'd109,
                               32'd110, 32'd111, 32'd112, 32'd113, 32'd114};
  logic [31:0] t4_rs1 [8]  = '{32'h10, 32'h20, 32'h30, 32'h40,
                               32'h50, 32'h60, 32'h70, 32'hFFFF_FFFF};
  logic [31:0] t4_rs2 [8]  = '{32'h1, 32'h2, 32'h3, 32'h4,
                               32'h5, 32'h6, 32'h7, 32'h1};
  logic [31:0] t4_exp [8]  = '{32'h11, 32'h22, 32'h33, 32'h44,
                               32'h55, 32'h66, 32'h77, 32'h0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one command (caller sits at a negedge); returns at the next negedge.
  task automatic send_cmd(input logic [31:0] insn, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [4:0] tag,
                          input logic [31:0] exp_rd, input bit expect_it);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_insn  = insn;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_tag   = tag;
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready stuck 0 for %0d cycles, required 1", n);
    end else begin
      @(posedge clock);
      if (expect_it) exp_q.push_back('{rd: exp_rd, tag: tag});
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: busy=%0d pending=%0d, required idle with none pending",
               name, busy, exp_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag_s);
    chk({tag_s, "_cmd_ready"},  64'(cmd_ready),  64'(1));
    chk({tag_s, "_scie_valid"}, 64'(scie_valid), 64'(0));
    chk({tag_s, "_scie_insn"},  64'(scie_insn),  64'(0));
    chk({tag_s, "_scie_rs1"},   64'(scie_rs1),   64'(0));
    chk({tag_s, "_scie_rs2"},   64'(scie_rs2),   64'(0));
    chk({tag_s, "_rsp_valid"},  64'(rsp_valid),  64'(0));
    chk({tag_s, "_rsp_rd"},     64'(rsp_rd),     64'(0));
    chk({tag_s, "_rsp_tag"},    64'(rsp_tag),    64'(0));
    chk({tag_s, "_busy"},       64'(busy),       64'(0));
  endtask

  initial begin
    fork
      // Monitor: samples mid-low-phase, away from both clock edges.
      forever begin
        @(negedge clock);
        #2;
        if (reset) begin
          if (scie_valid) begin
            issue_cnt++;
            issue_run++;
            if (issue_run > issue_max) issue_max = issue_run;
          end else begin
            issue_run = 0;
          end
          if (rsp_valid && rsp_ready) begin
            pop_run++;
            if (pop_run > pop_max) pop_max = pop_run;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rsp_unexpected: got rd=0x%0h tag=%0d, required no response",
                       rsp_rd, rsp_tag);
            end else begin
              rsp_t e;
              e = exp_q.pop_front();
              chk("rsp_rd",  64'(rsp_rd),  64'(e.rd));
              chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            end
          end else begin
            pop_run = 0;
          end
        end else begin
          issue_run = 0;
          pop_run   = 0;
        end
      end
    join_none

    // Reset state.
    #12;
    chk_reset_outputs("por");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Single op: latency and one-cycle issue strobe.
    rsp_ready = 1'b1;
    send_cmd(32'h0000_000B, 32'd79, 32'd0, 5'd3, 32'd79, 1'b1);
    chk("t1_no_early_issue", 64'(scie_valid), 64'(0));
    @(negedge clock);
    chk("t1_scie_valid", 64'(scie_valid), 64'(1));
    chk("t1_scie_insn",  64'(scie_insn),  64'(32'h0B));
    chk("t1_scie_rs1",   64'(scie_rs1),   64'(79));
    chk("t1_scie_rs2",   64'(scie_rs2),   64'(0));
    @(negedge clock);
    chk("t1_scie_valid_drop", 64'(scie_valid), 64'(0));
    chk("t1_rsp_not_yet",     64'(rsp_valid),  64'(0));
    @(negedge clock);
    chk("t1_rsp_valid_at_3", 64'(rsp_valid), 64'(1));
    wait_idle("t1_idle");
    chk("t1_busy", 64'(busy), 64'(0));

    // Back-to-back four commands with a draining consumer.
    issue_max = 0;
    pop_max   = 0;
    base      = issue_cnt;
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h0B, 32'd17 + 32'(i), 32'd1, 5'(i + 1), 32'd18 + 32'(i), 1'b1);
    end
    wait_idle("t2_idle");
    chk("t2_issues",     64'(issue_cnt - base), 64'(4));
    chk("t2_issue_run",  64'(issue_max),        64'(4));
    chk("t2_rsp_run",    64'(pop_max),          64'(4));

    // Backpressure: only RSP_DEPTH issues, command FIFO fills behind them.
    rsp_ready = 1'b0;
    base      = issue_cnt;
    for (int i = 0; i < 8; i++) begin
      send_cmd(32'h0B, t3_rs1[i], 32'd5, 5'(i + 5), t3_exp[i], 1'b1);
    end
    repeat (6) @(negedge clock);
    chk("t3_issues_capped", 64'(issue_cnt - base), 64'(4));
    chk("t3_cmd_ready_low", 64'(cmd_ready),        64'(0));
    chk("t3_rsp_valid",     64'(rsp_valid),        64'(1));
    chk("t3_busy",          64'(busy),             64'(1));
    rsp_ready = 1'b1;
    for (int i = 8; i < 10; i++) begin
      send_cmd(32'h0B, t3_rs1[i], 32'd5, 5'(i + 5), t3_exp[i], 1'b1);
    end
    wait_idle("t3_idle");
    chk("t3_issues_total", 64'(issue_cnt - base), 64'(10));

    // Steady state: issue, capture and pop every cycle without a stall.
    issue_max = 0;
    pop_max   = 0;
    for (int i = 0; i < 8; i++) begin
      send_cmd(32'h0B, t4_rs1[i], t4_rs2[i], 5'(i + 20), t4_exp[i], 1'b1);
    end
    wait_idle("t4_idle");
    chk("t4_issue_run", 64'(issue_max), 64'(8));
    chk("t4_rsp_run",   64'(pop_max),   64'(8));

    // Reset with work queued, in flight and buffered.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h0B, 32'd200 + 32'(i), 32'd0, 5'(i + 1), 32'd200 + 32'(i), 1'b1);
    end
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("t5_no_stale_rsp", 64'(rsp_valid), 64'(0));
    chk("t5_not_busy",     64'(busy),      64'(0));
    rsp_ready = 1'b1;
    send_cmd(32'h0B, 32'd99, 32'd1, 5'd9, 32'd100, 1'b1);
    wait_idle("t5_idle");

`ifdef SCIE_DISPATCH_FLUSH_EN
    // Flush with two in flight and three queued; buffered results survive.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h0B, 32'd40 + 32'(i), 32'd0, 5'(i + 10), 32'd40 + 32'(i), 1'b1);
    end
    repeat (8) @(negedge clock);
    base = issue_cnt;
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h0B, 32'd60 + 32'(i), 32'd0, 5'(i + 16), 32'd0, 1'b0);
    end
    repeat (4) @(negedge clock);
    chk("t6_blocked", 64'(issue_cnt - base), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    send_cmd(32'h0B, 32'd64, 32'd0, 5'd20, 32'd0, 1'b0);
    flush = 1'b1;
    #1;
    chk("t6_flush_ready", 64'(cmd_ready), 64'(0));
    @(negedge clock);
    flush = 1'b0;
    repeat (8) @(negedge clock);
    chk("t6_issues", 64'(issue_cnt - base), 64'(2));
    chk("t6_buffered", 64'(rsp_valid), 64'(1));
    rsp_ready = 1'b1;
    wait_idle("t6_idle");
`endif

    repeat (4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
